alu_control_sequencer: RTL
==========================

# alu_control_sequencer

Control sequencer for the single-bus datapath: it replaces hand-driven bench stimulus with a clocked FSM that drives `enable`, `busSelect`, `MD_Read` and `Control_Signals` through fetch (T0–T2) and execute (T3–T5) for register-to-register ALU instructions. It sits beside `datapath`. It reads the IR contents back from the datapath and waits on memory via a ready handshake. It loops fetch/execute while `run` is high.

## Interface
- `PC_INC_EN`, default 1: when 1, T0 asserts `enable[28]` (IncPC); when 0, the PC is not incremented.
- `clk` in 1: rising-edge clock.
- `clr` in 1: reset, asynchronous and active-high.
- `run` in 1: level-sensitive. Sampled in IDLE and at the end of each instruction.
- `mem_ready` in 1: memory read data is valid on `MDataIn` this cycle.
- `ir` in 32: current IR register value from the datapath.
- `enable` out 32: register load strobes, one-hot per function.
  - Bits 0–15: R0–R15.
  - 20: PC. 21: MDR. 23: IR. 24: Z. 25: MAR. 27: Y. 28: IncPC.
- `busSelect` out 32: bus driver selects.
  - Bits 0–15: R0–R15.
  - 19: Zlow. 20: PC. 21: MDR.
- `MD_Read` out 1: MDR source select and memory read request.
- `Control_Signals` out 4: ALU operation.
  - 0: none. 1: ADD. 2: SUB. 3: AND. 4: OR. 5: NEG. 6: NOT.
- `done` out 1: one-cycle pulse on the final execute cycle of a legal instruction.
- `illegal` out 1: one-cycle pulse in T3 for an undefined opcode.

## Operation
- Instruction fields:
  - opcode = `ir[31:27]`.
  - Ra = `ir[26:23]` (destination).
  - Rb = `ir[22:19]`.
  - Rc = `ir[18:15]`.
- Opcode map:
  - Binary: 00000 ADD, 00001 SUB, 00010 AND, 00011 OR.
  - Unary: 00100 NEG, 00101 NOT.
  - All others are illegal.
- States: IDLE, T0, T1, T2, T3, T4, T5. The state register is 3 bits. Outputs are Moore-decoded from the state plus `ir`. Any bit not listed for a state is 0.
- IDLE: all outputs 0. Go to T0 when `run`=1.
- T0:
  - Asserts `busSelect[20]`, `enable[25]`, `enable[24]`, plus `enable[28]` if `PC_INC_EN`.
  - Always goes to T1.
- T1:
  - Asserts `busSelect[19]`, `enable[20]`, `MD_Read`, `enable[21]`.
  - Holds while `mem_ready`=0; the repeated PC load of an unchanged Z is idempotent.
  - Goes to T2 on the cycle `mem_ready`=1.
- T2: asserts `busSelect[21]` and `enable[23]`. Goes to T3.
- T3, binary op: asserts `busSelect[Rb]` and `enable[27]`. Goes to T4.
- T3, unary op: asserts `busSelect[Rb]`, `Control_Signals`=op and `enable[24]`. Goes to T4.
- T3, illegal op: no datapath strobes; pulses `illegal`. Goes to T0 if `run`, else IDLE.
- T4, binary op: asserts `busSelect[Rc]`, `Control_Signals`=op and `enable[24]`. Goes to T5.
- T4, unary op: asserts `busSelect[19]` and `enable[Ra]`, pulses `done`. Goes to T0 if `run`, else IDLE.
- T5, binary op only: asserts `busSelect[19]` and `enable[Ra]`, pulses `done`. Goes to T0 if `run`, else IDLE.
- At most one `busSelect` bit is high in any cycle.
- Ra = R0 is writable; there is no hard-wired zero register.
- `ir` is decoded only in T3–T5. It is stable there because IR loads at the T2→T3 edge.

## Timing
- Reset (`clr`=1, asynchronous): state goes to IDLE immediately. `enable`, `busSelect`, `MD_Read`, `Control_Signals`, `done` and `illegal` are all 0 in the same delta, with no clock needed.
- Reset mid-instruction: the instruction is abandoned with no further strobes. A partially fetched IR is not reused.
- After `clr` falls: the first T0 occurs on the first rising edge with `run`=1.
- Latency with `mem_ready` tied to 1:
  - Binary op: 6 cycles, T0 to T5.
  - Unary op: 5 cycles.
  - Illegal op: 4 cycles.
- Each additional `mem_ready`=0 cycle in T1 adds exactly one cycle.
- `run` falling mid-instruction: the instruction completes, then the FSM enters IDLE.
- `run` going high again: the next T0 follows one cycle after IDLE samples it.
- `mem_ready` is ignored outside T1.

## Test plan
- Binary ADD:
  - Setup: R2=5, R3=6, `ir`=0x00918000 (ADD R1,R2,R3), `mem_ready`=1, `run`=1.
  - Required: states T0..T5 in 6 cycles; T4 `Control_Signals`=1 with `busSelect[3]`; T5 `enable[1]` and `done`; R1=11.
- Unary NEG:
  - Setup: R2=6, `ir`=0x20900000 (NEG R1,R2).
  - Required: T3 `busSelect[2]`, `Control_Signals`=5, `enable[24]`; T4 `enable[1]` and `done`; R1=0xFFFFFFFA; back to T0 after 5 cycles.
- Memory stall: hold `mem_ready`=0 for 3 cycles in T1.
  - Required: T1 outputs held for 4 cycles; `enable[23]` appears exactly once, the cycle after `mem_ready` rises.
- Illegal opcode: `ir`=0xF8000000.
  - Required: `illegal` pulses in T3; no `enable[0..15]` asserted; next state T0.
- Reset mid-T4 of an ADD: assert `clr` asynchronously.
  - Required: all outputs 0 before the next edge; IDLE; Ra unchanged.
- Run control: drop `run` during T2.
  - Required: the instruction completes through `done`, then IDLE with outputs 0; raising `run` gives T0 one cycle later.

Source files
------------

// File: rtl/alu_control_sequencer.sv
// -----------------------------------------------------------------------------
// alu_control_sequencer
//
// Clocked control FSM for the single-bus datapath. It runs instruction fetch
// (T0-T2) and execute (T3-T5) for register-to-register ALU instructions and
// loops fetch/execute for as long as `run` stays high.
//
// Parameters
//   PC_INC_EN        1 = T0 also asserts IncPC (enable[28]) so Z gets PC+1.
//
// Ports
//   clk              rising-edge clock
//   clr              asynchronous active-high reset (FSM returns to IDLE)
//   run              level-sensitive; sampled in IDLE and at instruction end
//   mem_ready        memory data valid on MDataIn (only looked at in T1)
//   ir[31:0]         IR contents read back from the datapath
//   enable[31:0]     register load strobes (R0-R15, PC, MDR, IR, Z, MAR, Y, IncPC)
//   busSelect[31:0]  bus driver selects (R0-R15, Zlow, PC, MDR); at most one high
//   MD_Read          MDR source select / memory read request
//   Control_Signals  ALU operation (0 none, 1 ADD .. 6 NOT)
//   done             one-cycle pulse on the last execute cycle of a legal op
//   illegal          one-cycle pulse in T3 for an undefined opcode
// -----------------------------------------------------------------------------
module alu_control_sequencer #(
    parameter bit PC_INC_EN = 1'b1
) (
    input  logic        clk,
    input  logic        clr,
    input  logic        run,
    input  logic        mem_ready,
    input  logic [31:0] ir,
    output logic [31:0] enable,
    output logic [31:0] busSelect,
    output logic        MD_Read,
    output logic [3:0]  Control_Signals,
    output logic        done,
    output logic        illegal
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_T0   = 3'd1;
    localparam logic [2:0] S_T1   = 3'd2;
    localparam logic [2:0] S_T2   = 3'd3;
    localparam logic [2:0] S_T3   = 3'd4;
    localparam logic [2:0] S_T4   = 3'd5;
    localparam logic [2:0] S_T5   = 3'd6;

    // Datapath bit positions
    localparam int EN_PC    = 20;
    localparam int EN_MDR   = 21;
    localparam int EN_IR    = 23;
    localparam int EN_Z     = 24;
    localparam int EN_MAR   = 25;
    localparam int EN_Y     = 27;
    localparam int EN_INCPC = 28;
    localparam int BS_ZLOW  = 19;
    localparam int BS_PC    = 20;
    localparam int BS_MDR   = 21;

    logic [2:0]  state_reg;
    logic [2:0]  state_next;

    // Instruction decode (meaningful only in T3-T5, where IR is stable)
    logic [4:0]  opcode;
    logic [3:0]  ra;
    logic [3:0]  rb;
    logic [3:0]  rc;
    logic        is_binary;
    logic        is_unary;
    logic [3:0]  alu_op;
    logic [15:0] ra_sel;
    logic [15:0] rb_sel;
    logic [15:0] rc_sel;
    logic        ir_unused;

    assign opcode    = ir[31:27];
    assign ra        = ir[26:23];
    assign rb        = ir[22:19];
    assign rc        = ir[18:15];
    assign ir_unused = ^ir[14:0];

    // Opcodes 0-3 are binary, 4-5 unary; the ALU code is simply opcode+1.
    assign is_binary = (opcode[4:2] == 3'b000);
    assign is_unary  = (opcode == 5'd4) || (opcode == 5'd5);
    assign alu_op    = {1'b0, opcode[2:0]} + 4'd1;

    // One-hot register selects for the three instruction fields
    generate
        for (genvar gi = 0; gi < 16; gi++) begin : g_reg_sel
            assign ra_sel[gi] = (ra == 4'(gi));
            assign rb_sel[gi] = (rb == 4'(gi));
            assign rc_sel[gi] = (rc == 4'(gi));
        end
    endgenerate

    // State register
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_reg <= S_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = S_IDLE;
        case (state_reg)
            S_IDLE: state_next = run ? S_T0 : S_IDLE;
            S_T0:   state_next = S_T1;
            // Stay in T1 until memory answers; reloading PC from an
            // unchanged Z each stall cycle is harmless.
            S_T1:   state_next = mem_ready ? S_T2 : S_T1;
            S_T2:   state_next = S_T3;
            S_T3: begin
                if (is_binary || is_unary) begin
                    state_next = S_T4;
                end else begin
                    state_next = run ? S_T0 : S_IDLE;
                end
            end
            S_T4: begin
                if (is_binary) begin
                    state_next = S_T5;
                end else begin
                    state_next = run ? S_T0 : S_IDLE;
                end
            end
            S_T5:   state_next = run ? S_T0 : S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // Moore output decode from state (plus IR fields in execute states)
    always_comb begin
        enable          = '0;
        busSelect       = '0;
        MD_Read         = 1'b0;
        Control_Signals = 4'd0;
        done            = 1'b0;
        illegal         = 1'b0;
        case (state_reg)
            S_T0: begin
                busSelect[BS_PC]  = 1'b1;
                enable[EN_MAR]    = 1'b1;
                enable[EN_Z]      = 1'b1;
                enable[EN_INCPC]  = PC_INC_EN;
            end
            S_T1: begin
                busSelect[BS_ZLOW] = 1'b1;
                enable[EN_PC]      = 1'b1;
                MD_Read            = 1'b1;
                enable[EN_MDR]     = 1'b1;
            end
            S_T2: begin
                busSelect[BS_MDR] = 1'b1;
                enable[EN_IR]     = 1'b1;
            end
            S_T3: begin
                if (is_binary) begin
                    busSelect[15:0] = rb_sel;
                    enable[EN_Y]    = 1'b1;
                end else if (is_unary) begin
                    busSelect[15:0] = rb_sel;
                    Control_Signals = alu_op;
                    enable[EN_Z]    = 1'b1;
                end else begin
                    illegal = 1'b1;
                end
            end
            S_T4: begin
                if (is_binary) begin
                    busSelect[15:0] = rc_sel;
                    Control_Signals = alu_op;
                    enable[EN_Z]    = 1'b1;
                end else if (is_unary) begin
                    busSelect[BS_ZLOW] = 1'b1;
                    enable[15:0]       = ra_sel;
                    done               = 1'b1;
                end
            end
            S_T5: begin
                if (is_binary) begin
                    busSelect[BS_ZLOW] = 1'b1;
                    enable[15:0]       = ra_sel;
                    done               = 1'b1;
                end
            end
            default: ;
        endcase
    end

endmodule
